lvds_rx_arbiter: RTL

- Merges the 32-bit sample-word streams of the two LVDS deserializer instances (900 MHz and 2.4 GHz modem channels) onto the single RX FIFO write port.
- Sequences each capture session (start/stop, optional sample limit) and arbitrates round-robin when both channels are enabled.
- Tags each word with its source channel and keeps drop/overflow statistics for the host register file.

---
 rtl/rx_pkg.sv | 21 ++
 rtl/lvds_rx_hold_slot.sv | 45 ++++
 rtl/lvds_rx_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared encodings for the LVDS RX arbiter: FSM states, channel modes and
// the channel tag that is spliced into every FIFO word.
package rx_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_09   = 2'b01;
  localparam logic [1:0] MODE_24   = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam int   TAG_BIT = 30;
  localparam logic TAG_09  = 1'b0;
  localparam logic TAG_24  = 1'b1;

  typedef struct packed {
    logic        vld;
    logic [31:0] data;
  } hold_t;
endpackage

// File: rtl/lvds_rx_hold_slot.sv
// One-word holding register for a deserializer channel, with drop detection
// and a saturating per-session drop counter.
module lvds_rx_hold_slot
  import rx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_cnt_clr,
  input  logic             i_en,
  input  logic             i_push,
  input  logic [31:0]      i_data,
  input  logic             i_grant,
  output hold_t            o_hold,
  output logic             o_drop,
  output logic [CNT_W-1:0] o_drop_cnt
);
  logic capture;

  // A word granted this cycle frees the slot, so a same-cycle push refills it.
  assign capture = i_en && i_push && (!o_hold.vld || i_grant);
  assign o_drop  = i_en && i_push && o_hold.vld && !i_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hold     <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (i_clr) begin
        o_hold.vld <= 1'b0;
      end else if (capture) begin
        o_hold.vld  <= 1'b1;
        o_hold.data <= i_data;
      end else if (i_grant) begin
        o_hold.vld <= 1'b0;
      end
      if (i_cnt_clr)
        o_drop_cnt <= '0;
      else if (o_drop && o_drop_cnt != '1)
        o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/lvds_rx_arbiter.sv
// Merges the ch09 and ch24 deserializer word streams onto the RX FIFO write
// port with session control, round-robin arbitration and drop statistics.
module lvds_rx_arbiter
  import rx_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_sample_limit,
  input  logic             i_push_09,
  input  logic [31:0]      i_data_09,
  input  logic             i_push_24,
  input  logic [31:0]      i_data_24,
  input  logic             i_fifo_full,
  output logic             o_fifo_push,
  output logic [31:0]      o_fifo_data,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_sample_cnt,
  output logic [CNT_W-1:0] o_drop_cnt_09,
  output logic [CNT_W-1:0] o_drop_cnt_24,
  output logic             o_overflow,
  output logic             o_done
);
  logic [1:0]                  state, mode_q;
  logic                        rr_ptr;  // channel that wins the next contention
  hold_t [1:0]                 hold;
  logic  [1:0]                 drop, gnt, en, push;
  logic  [1:0][31:0]           din;
  logic  [1:0][CNT_W-1:0]      drop_cnt;
  logic                        run, start_ok, gnt_any, gnt_ch, limit_hit, hold_clr;
  logic  [CNT_W-1:0]           cnt_nxt;

  assign run      = (state == ST_RUN);
  assign start_ok = i_start && !i_stop && (i_mode != MODE_NONE) && !run;
  assign en       = {2{run && !i_stop}} & mode_q;
  assign push     = {i_push_24, i_push_09};
  assign din      = {i_data_24, i_data_09};

  always_comb begin
    gnt = '0;
    if (run && !i_stop && !i_fifo_full) begin
      if (hold[0].vld && hold[1].vld) gnt = rr_ptr ? 2'b10 : 2'b01;
      else                            gnt = {hold[1].vld, hold[0].vld};
    end
  end

  assign gnt_any   = |gnt;
  assign gnt_ch    = gnt[1];
  assign cnt_nxt   = (o_sample_cnt == '1) ? o_sample_cnt : o_sample_cnt + 1'b1;
  // >= so a limit lowered below the running count still ends the session.
  assign limit_hit = gnt_any && (i_sample_limit != '0) && (cnt_nxt >= i_sample_limit);
  assign hold_clr  = i_stop || limit_hit;

  for (genvar g = 0; g < 2; g++) begin : g_slot
    lvds_rx_hold_slot #(.CNT_W(CNT_W)) u_slot (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clr      (hold_clr),
      .i_cnt_clr  (start_ok),
      .i_en       (en[g]),
      .i_push     (push[g]),
      .i_data     (din[g]),
      .i_grant    (gnt[g]),
      .o_hold     (hold[g]),
      .o_drop     (drop[g]),
      .o_drop_cnt (drop_cnt[g])
    );
  end

  assign o_drop_cnt_09 = drop_cnt[0];
  assign o_drop_cnt_24 = drop_cnt[1];
  assign o_state       = state;
  assign o_done        = (state == ST_DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      mode_q       <= MODE_NONE;
      rr_ptr       <= 1'b0;
      o_fifo_push  <= 1'b0;
      o_fifo_data  <= '0;
      o_sample_cnt <= '0;
      o_overflow   <= 1'b0;
    end else begin
      o_fifo_push <= gnt_any;
      if (gnt_any) begin
        o_fifo_data          <= hold[gnt_ch].data;
        o_fifo_data[TAG_BIT] <= gnt_ch ? TAG_24 : TAG_09;
        o_sample_cnt         <= cnt_nxt;
        if (hold[0].vld && hold[1].vld) rr_ptr <= ~rr_ptr;
      end
      if (|drop) o_overflow <= 1'b1;

      if (i_stop) begin
        state <= ST_IDLE;
      end else if (start_ok) begin
        state        <= ST_RUN;
        mode_q       <= i_mode;
        o_sample_cnt <= '0;
        o_overflow   <= 1'b0;
      end else if (limit_hit) begin
        state <= ST_DONE;
      end
    end
  end
endmodule
